// File: rtl/modacc_pkg.sv
// modacc_pkg: FSM state enum, err bit indices and modulus builder q = {qH, 0..0, 1} shared by modacc and modadd
package modacc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} modacc_state_t;
  localparam int ERR_RANGE = 0;
  localparam int ERR_SAT = 1;
  localparam int QMAX = 128;
  function automatic logic [QMAX-1:0] modacc_q(input logic [QMAX-1:0] qh, input int logq, input int logqh);
    return (qh << (logq - logqh)) | QMAX'(1);
  endfunction
endpackage

// File: rtl/modacc_if.sv
// modacc_if: modacc stream bus (qH, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_count/out_err); slave = accumulator side, master = environment side
interface modacc_if #(parameter int LOGQ = 64, parameter int LOGQH = 47, parameter int CNTW = 16);
  logic [LOGQH-1:0] qH;
  logic in_valid;
  logic in_ready;
  logic [LOGQ-1:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [LOGQ-1:0] out_data;
  logic [CNTW-1:0] out_count;
  logic [1:0] out_err;
  modport slave (input qH, in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_count, out_err);
  modport master (output qH, in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_count, out_err);
endinterface

// File: rtl/modadd.sv
// modadd: o_sum = (i_a + i_b) mod q with one conditional subtract, q built from i_qh; FF_IN/FF_ADD/FF_OUT select optional register stages (clk, rst_n async active-low)
module modadd import modacc_pkg::*; #(
  parameter int LOGA = 64,
  parameter int LOGB = 64,
  parameter int LOGQ = 64,
  parameter int LOGQH = 47,
  parameter int FF_IN = 0,
  parameter int FF_ADD = 0,
  parameter int FF_OUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [LOGA-1:0] i_a,
  input  logic [LOGB-1:0] i_b,
  input  logic [LOGQH-1:0] i_qh,
  output logic [LOGQ-1:0] o_sum
);
  logic [LOGA-1:0] r_a;
  logic [LOGB-1:0] r_b;
  logic [LOGQ:0] r_s;
  logic [LOGQ-1:0] r_o;
  logic [LOGA-1:0] w_a;
  logic [LOGB-1:0] w_b;
  logic [LOGQ:0] w_q;
  logic [LOGQ:0] w_s;
  logic [LOGQ:0] w_sp;
  logic [LOGQ-1:0] w_r;
  assign w_a = (FF_IN != 0) ? r_a : i_a;
  assign w_b = (FF_IN != 0) ? r_b : i_b;
  assign w_q = (LOGQ+1)'(modacc_q(QMAX'(i_qh), LOGQ, LOGQH));
  assign w_s = (LOGQ+1)'(w_a) + (LOGQ+1)'(w_b);
  assign w_sp = (FF_ADD != 0) ? r_s : w_s;
  assign w_r = LOGQ'((w_sp >= w_q) ? w_sp - w_q : w_sp);
  assign o_sum = (FF_OUT != 0) ? r_o : w_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_o <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
      r_s <= w_s;
      r_o <= w_r;
    end
endmodule

// File: rtl/modacc.sv
// modacc: streaming per-frame sum mod q with beat count and error flags; ports clk, rst_n (async active-low), s (modacc_if.slave: qH, in_* stream, out_* result)
module modacc import modacc_pkg::*; #(
  parameter int LOGQ = 64,
  parameter int LOGQH = 47,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst_n,
  modacc_if.slave s
);
  modacc_state_t r_state, w_next;
  logic [LOGQ-1:0] r_acc, r_od, w_sum, w_q;
  logic [CNTW-1:0] r_cnt, r_oc, w_cnt;
  logic [1:0] r_err, r_oe, w_err;
  logic w_rdy, w_beat, w_bad, w_sat;
  assign w_q = LOGQ'(modacc_q(QMAX'(s.qH), LOGQ, LOGQH));
  assign w_bad = s.in_data >= w_q;
  assign w_sat = &r_cnt;
  assign w_cnt = w_sat ? r_cnt : r_cnt + 1'b1;
  modadd #(
    .LOGA(LOGQ), .LOGB(LOGQ), .LOGQ(LOGQ), .LOGQH(LOGQH),
    .FF_IN(0), .FF_ADD(0), .FF_OUT(0)
  ) u_add (
    .clk(clk), .rst_n(rst_n), .i_a(r_acc), .i_b(s.in_data), .i_qh(s.qH), .o_sum(w_sum)
  );
  // acc/count/err are zero outside ACC, so IDLE and DONE frames start from them directly
  always_comb begin
    w_rdy = rst_n && (r_state != DONE || s.out_ready);
    w_beat = s.in_valid && w_rdy;
    w_next = w_beat ? (s.in_last ? DONE : ACC) : (r_state == DONE && s.out_ready) ? IDLE : r_state;
    w_err = r_err;
    w_err[ERR_RANGE] = r_err[ERR_RANGE] | w_bad;
    w_err[ERR_SAT] = r_err[ERR_SAT] | w_sat;
  end
  assign s.in_ready = w_rdy;
  assign s.out_valid = r_state == DONE;
  assign s.out_data = r_od;
  assign s.out_count = r_oc;
  assign s.out_err = r_oe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= '0;
      r_od <= '0;
      r_oc <= '0;
      r_oe <= '0;
    end else if (w_beat && s.in_last) begin
      r_od <= w_sum;
      r_oc <= w_cnt;
      r_oe <= w_err;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= '0;
    end else if (w_beat) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
endmodule

// File: doc/modacc.md
# modacc

Streaming modular accumulator for moduli of the form q = qH·2^(LOGQ−LOGQH) + 1. It consumes a valid/ready stream of residues in [0, q) from the upstream modular-arithmetic datapath and reduces each frame to a single residue ∑x mod q. It reports the frame length and error flags with each result. Each accumulation step uses one fully combinational `modadd` instance as its adder, with all FF_* parameters set to 0.

## Interface
- LOGQ, default 64: residue / modulus width.
- LOGQH, default 47: width of qH. W = LOGQ − LOGQH and must be ≥ 1.
- CNTW, default 16: width of the beat counter and of `out_count`.
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- qH, input, LOGQH: modulus high part, q = {qH, (W−1)'b0, 1'b1}. It must be static for a whole frame and is sampled on every accepted beat.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, LOGQ: residue; legal range [0, q).
- in_last, input, 1: the beat closes its frame.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, LOGQ: frame sum mod q.
- out_count, output, CNTW: number of beats in the frame, saturating.
- out_err, output, 2: bit0 = some in_data ≥ q; bit1 = beat count saturated.

## Operation
- Accepted beat: in_valid && in_ready at a rising clk edge.
- Step function: acc ⊕ x = (acc + x − q ≥ 0) ? acc + x − q : acc + x.
  - Intermediate values are LOGQ+1 bits wide. The result is truncated to LOGQ bits.
  - acc + x ≤ 2q − 2 for legal inputs, so one conditional subtract is sufficient.
- Range check on every accepted beat: if in_data ≥ q, set the frame's err0. The step is still applied as written; the sum is then undefined but deterministic.
- The count increments per accepted beat. At 2^CNTW − 1 it holds that value and sets the frame's err1.
- FSM states are IDLE, ACC and DONE.
  - IDLE: acc = 0, count = 0, out_valid = 0, in_ready = 1.
    - Beat with !last → ACC, with acc = x reduced and count = 1.
    - Beat with last → DONE.
  - ACC: in_ready = 1.
    - Beat with !last → ACC, with acc ⊕= x.
    - Beat with last → DONE. The output registers take acc ⊕ x, count+1 and the errors. acc, count and the errors clear.
  - DONE: out_valid = 1 and in_ready = out_ready (combinational).
    - out_ready with no beat → IDLE.
    - out_ready with a beat and !last → ACC; the new frame starts from acc = 0.
    - out_ready with a beat and last → DONE with the new single-beat result.
    - !out_ready → stay in DONE. out_data, out_count and out_err are held stable.
- The output registers load only on the DONE-entry edge and are otherwise held.
- If qH changes mid-frame, the result is undefined. No checking is done.

## Timing
- Latency: the result appears on out_* in the cycle after the last beat is accepted (1 cycle). There is no combinational path from in_data to out_data.
- Throughput: one beat per cycle, including across frame boundaries, when out_ready = 1.
- Only combinational paths: out_ready → in_ready in DONE, and qH → range check / step.
- Reset: on rst_n low, all of the following take effect immediately, independent of clk:
  - state = IDLE.
  - acc, count and error accumulators = 0.
  - out_valid = 0, out_data = 0, out_count = 0, out_err = 0.
  - in_ready is forced to 0 while rst_n is low.
  - The first accepted beat is on the first rising edge after rst_n deasserts with in_valid high.
- Reset mid-frame or in DONE discards the partial or pending result. Nothing is emitted.
- A beat presented in DONE with out_ready = 0 is not accepted (in_ready = 0), and upstream holds it.

## Structure
- Package `modacc_pkg` contains:
  - `modacc_state_t`, the enum {IDLE, ACC, DONE};
  - the function `modacc_q(qH)` that builds q;
  - localparams for the err bit indices.
- Sub-module: one `modadd` with LOGA = LOGB = LOGQ, LOGQ, LOGQH, and FF_IN = FF_ADD = FF_OUT = 0, computing acc ⊕ x.
- Everything else (FSM, counter, range compare, output registers) lives in `modacc`.
- Expected size: about 150–200 RTL lines.

## Test plan
All scenarios use LOGQ = 8, LOGQH = 5, CNTW = 4, qH = 12, so W = 3 and q = 97.
- Frame 50, 40, 30 (last on 30), out_ready = 1 → one cycle after last: out_valid = 1, out_data = 23, out_count = 3, out_err = 0.
- Single beat 96 with last → out_data = 96, count = 1. Frame 96, 1 → out_data = 0 (exact q wrap).
- Backpressure:
  - After the result, hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0, and out_* stay stable.
  - Raise out_ready with beat 10 (!last) in the same cycle → the result retires and the beat is accepted.
  - Next frame 10, 5 (last) → out_data = 15.
- in_data = 100 inside frame 100, 3 (last) → out_err[0] = 1 and out_data = 6. The following legal frame reports out_err = 0.
- Frame of 16 beats of 1 → out_count = 15 (saturated), out_err[1] = 1, out_data = 16.
- Assert rst_n = 0 asynchronously, mid-cycle, after 50, 40 → out_valid and out_data go to 0 immediately. After release, frame 7 (last) → out_data = 7, count = 1.
